// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, fetches over req/ack and
// buffers up to two {pc, inst} entries for decode.
module fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'h0001
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [15:0] id_inst,
  output logic [15:0] id_pc,
  output logic [15:0] id_npc
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_req_pc;
  logic [15:0] w_req_pc_nx;
  logic [15:0] r_pend_pc;
  logic [15:0] w_pend_pc_nx;
  logic [15:0] r_pc   [2];
  logic [15:0] r_inst [2];
  logic        r_rd;
  logic        r_wr;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_nx;
  logic        w_push;
  logic        w_flush;
  logic        w_pop;

  assign w_pop = (r_cnt != 2'd0) & id_ready & ~w_flush;

  always_comb begin
    w_state_nx   = r_state;
    w_req_pc_nx  = r_req_pc;
    w_pend_pc_nx = r_pend_pc;
    w_push       = 1'b0;
    w_flush      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_state_nx = S_REQ;
        if (redirect) w_req_pc_nx = redirect_pc;
      end
      S_REQ: begin
        if (imem_ack && redirect) begin
          w_flush     = 1'b1;
          w_req_pc_nx = redirect_pc;
        end else if (imem_ack) begin
          w_push      = 1'b1;
          w_req_pc_nx = r_req_pc + PC_INC;
          // one entry held and nothing leaving: the push fills the buffer
          if (r_cnt == 2'd1 && !id_ready) w_state_nx = S_HOLD;
        end else if (redirect) begin
          w_flush      = 1'b1;
          w_pend_pc_nx = redirect_pc;
          w_state_nx   = S_DROP;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          w_flush     = 1'b1;
          w_req_pc_nx = redirect_pc;
          w_state_nx  = S_REQ;
        end else if (id_ready) begin
          w_state_nx = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) w_pend_pc_nx = redirect_pc;
        if (imem_ack) begin
          w_req_pc_nx = redirect ? redirect_pc : r_pend_pc;
          w_state_nx  = S_REQ;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nx = r_cnt;
    if (w_flush) w_cnt_nx = 2'd0;
    else w_cnt_nx = r_cnt + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_req_pc  <= RESET_PC;
      r_pend_pc <= RESET_PC;
      r_pc[0]   <= 16'h0000;
      r_pc[1]   <= 16'h0000;
      r_inst[0] <= 16'h0000;
      r_inst[1] <= 16'h0000;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_cnt     <= 2'd0;
    end else begin
      r_state   <= w_state_nx;
      r_req_pc  <= w_req_pc_nx;
      r_pend_pc <= w_pend_pc_nx;
      r_cnt     <= w_cnt_nx;
      if (w_flush) begin
        r_rd <= 1'b0;
        r_wr <= 1'b0;
      end else begin
        if (w_push) begin
          r_pc[r_wr]   <= r_req_pc;
          r_inst[r_wr] <= imem_rdata;
          r_wr         <= ~r_wr;
        end
        if (w_pop) r_rd <= ~r_rd;
      end
    end
  end

  assign imem_req  = (r_state == S_REQ) || (r_state == S_DROP);
  assign imem_addr = r_req_pc;
  assign id_valid  = (r_cnt != 2'd0);
  assign id_inst   = r_inst[r_rd];
  assign id_pc     = r_pc[r_rd];
  assign id_npc    = r_pc[r_rd] + PC_INC;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run
// against an in-order fetch-stream reference model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] rdata = 16'h0000;
  logic        redirect = 1'b0;
  logic [15:0] rpc = 16'h0000;
  logic        ready = 1'b0;
  logic        sel = 1'b0;

  logic        req0, req1, valid0, valid1;
  logic [15:0] addr0, addr1, inst0, inst1;
  logic [15:0] pc0, pc1, npc0, npc1;
  logic        req, valid;
  logic [15:0] addr, inst, pc, npc;

  int vec = 0;
  int errs = 0;
  int mem_wait = 0;
  int mem_lat = 0;
  logic        last_ack;
  logic        last_req;
  logic [15:0] last_addr;

  always #5 clk = ~clk;

  fetch_stage u0 (
    .clk(clk), .rst(rst),
    .imem_req(req0), .imem_addr(addr0),
    .imem_ack(ack), .imem_rdata(rdata),
    .redirect(redirect), .redirect_pc(rpc),
    .id_valid(valid0), .id_ready(ready),
    .id_inst(inst0), .id_pc(pc0), .id_npc(npc0)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) u1 (
    .clk(clk), .rst(rst),
    .imem_req(req1), .imem_addr(addr1),
    .imem_ack(ack), .imem_rdata(rdata),
    .redirect(redirect), .redirect_pc(rpc),
    .id_valid(valid1), .id_ready(ready),
    .id_inst(inst1), .id_pc(pc1), .id_npc(npc1)
  );

  assign req   = sel ? req1 : req0;
  assign addr  = sel ? addr1 : addr0;
  assign valid = sel ? valid1 : valid0;
  assign inst  = sel ? inst1 : inst0;
  assign pc    = sel ? pc1 : pc0;
  assign npc   = sel ? npc1 : npc0;

  // memory: acks after mem_lat waiting cycles, data = addr ^ A500
  task automatic cyc();
    ack   = req && (mem_wait >= mem_lat);
    rdata = addr ^ 16'hA500;
    last_ack  = ack;
    last_req  = req;
    last_addr = addr;
    @(posedge clk);
    #1;
    mem_wait = last_ack ? 0 : (last_req ? mem_wait + 1 : 0);
    ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    ack = 1'b0;
    redirect = 1'b0;
    ready = 1'b0;
    mem_wait = 0;
    mem_lat = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    sel = 1'b0;
    @(posedge clk);
    #1;
    vec++; if (req !== 1'b0) begin errs++; $display("FAIL rst_req got %b exp 0", req); end
    vec++; if (addr !== 16'h0000) begin errs++; $display("FAIL rst_addr got %h exp 0000", addr); end
    vec++; if (valid !== 1'b0) begin errs++; $display("FAIL rst_valid got %b exp 0", valid); end
    vec++; if (inst !== 16'h0000) begin errs++; $display("FAIL rst_inst got %h exp 0000", inst); end
    vec++; if (pc !== 16'h0000) begin errs++; $display("FAIL rst_pc got %h exp 0000", pc); end
    vec++; if (npc !== 16'h0001) begin errs++; $display("FAIL rst_npc got %h exp 0001", npc); end
    rst = 1'b1;
    cyc();
    vec++; if (req !== 1'b1) begin errs++; $display("FAIL first_req got %b exp 1", req); end
  endtask

  task automatic test_straight();
    ready = 1'b1;
    mem_lat = 0;
    for (int k = 0; k < 8; k++) begin
      logic [15:0] e;
      e = 16'(k);
      cyc();
      vec++;
      if ({valid, pc, inst, npc} !== {1'b1, e, e ^ 16'hA500, e + 16'h1}) begin
        errs++;
        $display("FAIL straight v/pc/inst/npc got %b %h %h %h exp 1 %h %h %h",
                 valid, pc, inst, npc, e, e ^ 16'hA500, e + 16'h1);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    ready = 1'b0;
    cyc();
    cyc();
    vec++; if (req !== 1'b0) begin errs++; $display("FAIL bp_req got %b exp 0", req); end
    vec++; if (pc !== 16'h0000) begin errs++; $display("FAIL bp_pc got %h exp 0000", pc); end
    cyc();
    vec++; if ({req, pc} !== {1'b0, 16'h0000}) begin errs++; $display("FAIL bp_hold got %b %h exp 0 0000", req, pc); end
    ready = 1'b1;
    cyc();
    vec++; if ({req, addr, pc} !== {1'b1, 16'h0002, 16'h0001}) begin
      errs++; $display("FAIL bp_release req/addr/pc got %b %h %h exp 1 0002 0001", req, addr, pc);
    end
    cyc();
    vec++; if ({valid, pc} !== {1'b1, 16'h0002}) begin
      errs++; $display("FAIL bp_next got %b %h exp 1 0002", valid, pc);
    end
  endtask

  task automatic test_redirect_hold();
    do_reset();
    ready = 1'b0;
    cyc();
    cyc();
    ready = 1'b1;
    redirect = 1'b1;
    rpc = 16'h0040;
    cyc();
    redirect = 1'b0;
    vec++; if ({valid, req, addr} !== {1'b0, 1'b1, 16'h0040}) begin
      errs++; $display("FAIL rdh valid/req/addr got %b %b %h exp 0 1 0040", valid, req, addr);
    end
    cyc();
    vec++; if ({valid, pc} !== {1'b1, 16'h0040}) begin
      errs++; $display("FAIL rdh_next got %b %h exp 1 0040", valid, pc);
    end
  endtask

  task automatic test_redirect_delay();
    do_reset();
    ready = 1'b1;
    repeat (5) cyc();
    vec++; if (addr !== 16'h0005) begin errs++; $display("FAIL rdd_pre addr got %h exp 0005", addr); end
    mem_lat = 3;
    redirect = 1'b1;
    rpc = 16'h0200;
    cyc();
    vec++; if ({valid, req, addr} !== {1'b0, 1'b1, 16'h0005}) begin
      errs++; $display("FAIL rdd_drop got %b %b %h exp 0 1 0005", valid, req, addr);
    end
    rpc = 16'h0080;
    cyc();
    redirect = 1'b0;
    cyc();
    vec++; if ({valid, addr} !== {1'b0, 16'h0005}) begin
      errs++; $display("FAIL rdd_stale got %b %h exp 0 0005", valid, addr);
    end
    cyc();
    vec++; if ({valid, req, addr} !== {1'b0, 1'b1, 16'h0080}) begin
      errs++; $display("FAIL rdd_target got %b %b %h exp 0 1 0080", valid, req, addr);
    end
    mem_lat = 0;
    cyc();
    vec++; if ({valid, pc, inst} !== {1'b1, 16'h0080, 16'h0080 ^ 16'hA500}) begin
      errs++; $display("FAIL rdd_deliver got %b %h %h exp 1 0080 %h", valid, pc, inst, 16'h0080 ^ 16'hA500);
    end
  endtask

  task automatic test_redirect_ack();
    mem_lat = 0;
    ready = 1'b1;
    cyc();
    redirect = 1'b1;
    rpc = 16'h0100;
    cyc();
    redirect = 1'b0;
    vec++; if ({valid, req, addr} !== {1'b0, 1'b1, 16'h0100}) begin
      errs++; $display("FAIL rda got %b %b %h exp 0 1 0100", valid, req, addr);
    end
    cyc();
    vec++; if ({valid, pc} !== {1'b1, 16'h0100}) begin
      errs++; $display("FAIL rda_next got %b %h exp 1 0100", valid, pc);
    end
  endtask

  task automatic test_wrap_reset();
    sel = 1'b1;
    do_reset();
    ready = 1'b1;
    cyc();
    vec++; if ({valid, pc} !== {1'b1, 16'hFFFE}) begin errs++; $display("FAIL wrap0 got %b %h exp 1 fffe", valid, pc); end
    cyc();
    vec++; if ({valid, pc} !== {1'b1, 16'hFFFF}) begin errs++; $display("FAIL wrap1 got %b %h exp 1 ffff", valid, pc); end
    cyc();
    vec++; if ({valid, pc, npc} !== {1'b1, 16'h0000, 16'h0001}) begin
      errs++; $display("FAIL wrap2 got %b %h %h exp 1 0000 0001", valid, pc, npc);
    end
    mem_lat = 3;
    cyc();
    vec++; if (req !== 1'b1) begin errs++; $display("FAIL wrap_out req got %b exp 1", req); end
    #2;
    rst = 1'b0;
    #1;
    vec++; if ({req, valid, addr} !== {1'b0, 1'b0, 16'hFFFE}) begin
      errs++; $display("FAIL async_rst got %b %b %h exp 0 0 fffe", req, valid, addr);
    end
    @(posedge clk);
    #1;
    ack = 1'b1;
    @(posedge clk);
    #1;
    ack = 1'b0;
    vec++; if ({req, valid} !== 2'b00) begin errs++; $display("FAIL rst_ack got %b %b exp 0 0", req, valid); end
    rst = 1'b1;
    mem_lat = 0;
    mem_wait = 0;
    cyc();
    cyc();
    vec++; if ({valid, pc} !== {1'b1, 16'hFFFE}) begin
      errs++; $display("FAIL restart got %b %h exp 1 fffe", valid, pc);
    end
  endtask

  // model: decode sees consecutive PCs from the last redirect target
  task automatic test_random();
    logic [15:0] exp_pc;
    logic        pv;
    logic [15:0] ppc, pinst, pnpc;
    sel = 1'b0;
    do_reset();
    exp_pc = 16'h0000;
    for (int i = 0; i < 400; i++) begin
      ready = ($urandom_range(0, 9) < 7);
      redirect = ($urandom_range(0, 15) == 0);
      rpc = 16'($urandom);
      if (mem_wait == 0) mem_lat = $urandom_range(0, 2);
      pv = valid;
      ppc = pc;
      pinst = inst;
      pnpc = npc;
      cyc();
      if (pv && ready && !redirect) begin
        vec++;
        if ({ppc, pinst, pnpc} !== {exp_pc, exp_pc ^ 16'hA500, exp_pc + 16'h1}) begin
          errs++;
          $display("FAIL rnd_pop pc/inst/npc got %h %h %h exp %h %h %h",
                   ppc, pinst, pnpc, exp_pc, exp_pc ^ 16'hA500, exp_pc + 16'h1);
        end
        exp_pc = exp_pc + 16'h1;
      end
      if (redirect) begin
        exp_pc = rpc;
        vec++;
        if (valid !== 1'b0) begin errs++; $display("FAIL rnd_flush valid got %b exp 0", valid); end
      end
      if (last_req && !last_ack) begin
        vec++;
        if (addr !== last_addr) begin
          errs++; $display("FAIL rnd_addr_stable got %h exp %h", addr, last_addr);
        end
      end
      redirect = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_straight();
    test_backpressure();
    test_redirect_hold();
    test_redirect_delay();
    test_redirect_ack();
    test_wrap_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
